bg_fetch_sched: RTL and testbench
=================================

# bg_fetch_sched

Per-scanline VRAM fetch scheduler for the four background layers of the PPU. It owns the fetch-x counter and decodes the 8-slot access pattern for the current BG mode. It drives every `bg` instance's `mode`, `x`, `fetch_map`, `fetch_data`, `fetch_data_num` and `newline` inputs, and selects which layer's `vram_addr` reaches VRAM. Idle slots and blanking periods are reported so the CPU/DMA port can use VRAM.

## Interface
- `LINE_DOTS`, 264: fetch dots per line (x = 0..LINE_DOTS-1).
- `clk` in 1: PPU clock.
- `reset_n` in 1: synchronous, active-low reset.
- `dot_en` in 1: dot-clock enable. All state advances only when it is high.
- `line_start` in 1: qualified by `dot_en`. Starts the fetch window of a visible line.
- `y_in` in 8: current line (0..239), passed through to the layers.
- `bg_mode` in 3: BGMODE register value (0..7).
- `force_blank` in 1: suppresses all fetches.
- `x` out 9: fetch coordinate shared by all layers. Reset value 0.
- `y` out 8: latched `y_in`. Reset value 0.
- `newline` out 1: high for the `line_start` cycle. Reset value 0.
- `layer_mode` out 4×3: per-layer `bg` mode code (000 OPT2/6, 100 OPT4, 001/010/011 2/4/8bpp, 101/110 hi-res). Reset value 0.
- `layer_en` out 4: layer is fetched in the current mode. Reset value 0.
- `fetch_map` out 4: per-layer map/OPT fetch strobe. Reset value 0.
- `fetch_data` out 4: per-layer character fetch strobe. Reset value 0.
- `fetch_data_num` out 4×3: per-layer word number. Reset value 0.
- `vram_sel` out 3: owning layer 0..3, or 4 = none. Reset value 4.
- `vram_free` out 1: VRAM available to CPU/DMA this dot. Reset value 1.

## Operation
- States:
  - IDLE (after reset): waits for `line_start`.
  - FETCH: x counts 0..LINE_DOTS-1.
  - HOLD: x is frozen after the window.
- Transitions:
  - On `dot_en & line_start` from any state: go to FETCH, set x=0, latch `bg_mode`→mode_q, latch `y_in`→y.
  - In FETCH, each `dot_en` increments x. At x=LINE_DOTS-1 the next `dot_en` moves to HOLD with x unchanged.
- Slot = x[2:0]. Table entries are Mn = layer n map, Dn.k = layer n data with `fetch_data_num`=k, On.k = layer n OPT map with num=k, "-" = idle. Slots 0..7 per mode:
  - Mode 0: M1 M2 M3 M4 D1.0 D2.0 D3.0 D4.0
  - Mode 1: M1 M2 M3 D1.0 D1.2 D2.0 D2.2 D3.0
  - Mode 2: M1 M2 O3.0 O3.1 D1.0 D1.2 D2.0 D2.2
  - Mode 3: M1 M2 D1.0 D1.2 D1.4 D1.6 D2.0 D2.2
  - Mode 4: M1 M2 O3.0 D1.0 D1.2 D1.4 D1.6 D2.0
  - Mode 5: M1 M2 D1.0 D1.1 D1.2 D1.3 D2.0 D2.1
  - Mode 6: M1 O3.0 O3.1 D1.0 D1.1 D1.2 D1.3 -
  - Mode 7: all "-"; `layer_en`=0.
- `layer_mode` per mode, listed BG1..BG3 (all other layers 000 with `layer_en`=0):
  - Mode 0: 001 for all four layers.
  - Mode 1: 010, 010, 001.
  - Mode 2: 010, 010, 000.
  - Mode 3: 011, 010.
  - Mode 4: 011, 001, 100.
  - Mode 5: 110, 101.
  - Mode 6: 110, BG2 off, BG3 000.
- Strobes are asserted only in FETCH with `force_blank`=0. Otherwise all strobes are 0, `vram_sel`=4 and `vram_free`=1.
- `vram_free`=1 exactly when `vram_sel`=4.
- Exactly one bit of `fetch_map|fetch_data` is set at any time, or none.
- `fetch_data_num` of a layer that is not strobed holds 0.

## Timing
- x, y, state and mode_q are registers. Strobes, `vram_sel`, `layer_mode` and `layer_en` decode combinationally from them, so they are stable for the whole dot and the `bg` instance samples VRAM data on the `dot_en` cycle.
- Zero-latency strobes: slot k is presented while x[2:0]=k.
- A `bg_mode` change mid-line takes effect only at the next `line_start`.
- `line_start` during FETCH restarts the line at x=0. The restart wins over the increment.
- `force_blank` acts on the same dot and does not stop x.
- `reset_n`=0 mid-line: return to IDLE and reset all outputs to their reset values on the next clock.

## Configuration
- `BG_FETCH_OPT_EN` defined: modes 2, 4 and 6 schedule the OPT slots and BG3 `layer_en`=1.
- Undefined: OPT slots become idle ("-", `vram_free`=1), BG3 `layer_en`=0 and its `layer_mode`=000 in those modes. Other modes are unchanged.

## Structure
- `ppu_pkg` holds:
  - a `fetch_slot_type` struct {kind: map/data/opt/idle; layer[1:0]; num[2:0]};
  - `VRAM_SEL_NONE`=3'd4;
  - the 8×8 schedule table as a constant function `fetch_slot(mode, slot)`.
- Sub-module `bg_fetch_decode` is purely combinational and maps (mode_q, slot, active) to the per-layer strobes and `vram_sel`. The top level holds the FSM and counters.

## Test plan
- Mode 1, `line_start`, 16 dots → at x=3 `fetch_data[0]`=1 with num 0; at x=4 num 2; at x=7 `fetch_data[2]`=1 with num 0; `vram_sel` sequence 0,1,2,0,0,1,1,2.
- Mode 2 with `BG_FETCH_OPT_EN` → x=2 `fetch_map[2]`=1 with num 0, x=3 num 1, `layer_mode[2]`=000. Without the macro → x=2,3 have `vram_sel`=4 and `vram_free`=1.
- Mode 7 full line → no strobes for 264 dots, `vram_free`=1 throughout.
- `bg_mode` switched 0→3 at x=100 → schedule stays mode 0 until the next `line_start`, then x=2 gives D1.0 with `layer_mode[0]`=011.
- `force_blank` pulsed for x=40..47 → no strobes in that window, x still reaches 263, then HOLD freezes x=263.
- `reset_n` low at x=130 → next clock x=0, `vram_sel`=4, state IDLE. No strobe until the next `line_start`.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types and the BG fetch schedule table.
// BG_FETCH_OPT_EN enables the offset-per-tile fetch slots in modes 2, 4 and 6.
package ppu_pkg;

  localparam logic [2:0] VRAM_SEL_NONE = 3'd4;

`ifdef BG_FETCH_OPT_EN
  localparam logic OPT_EN = 1'b1;
`else
  localparam logic OPT_EN = 1'b0;
`endif

  localparam logic [2:0] LM_OPT2 = 3'b000;
  localparam logic [2:0] LM_OPT4 = 3'b100;
  localparam logic [2:0] LM_2BPP = 3'b001;
  localparam logic [2:0] LM_4BPP = 3'b010;
  localparam logic [2:0] LM_8BPP = 3'b011;
  localparam logic [2:0] LM_HI2  = 3'b101;
  localparam logic [2:0] LM_HI4  = 3'b110;

  typedef enum logic [1:0] {
    K_MAP,
    K_DATA,
    K_OPT,
    K_IDLE
  } slot_kind_t;

  typedef struct packed {
    slot_kind_t kind;
    logic [1:0] layer;
    logic [2:0] num;
  } fetch_slot_type;

  typedef struct packed {
    logic [11:0] lmode;
    logic [3:0]  en;
  } layer_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
  } fetch_state_t;

  function automatic fetch_slot_type mk_slot(
    input slot_kind_t k,
    input logic [1:0] l,
    input logic [2:0] n
  );
    fetch_slot_type s;
    s.kind  = k;
    s.layer = l;
    s.num   = n;
    return s;
  endfunction

  function automatic fetch_slot_type f_idle();
    return mk_slot(K_IDLE, 2'd0, 3'd0);
  endfunction

  function automatic fetch_slot_type f_map(input logic [1:0] l);
    return mk_slot(K_MAP, l, 3'd0);
  endfunction

  function automatic fetch_slot_type f_dat(
    input logic [1:0] l,
    input logic [2:0] n
  );
    return mk_slot(K_DATA, l, n);
  endfunction

  // OPT slots collapse to idle when the feature is built out
  function automatic fetch_slot_type f_opt(
    input logic [1:0] l,
    input logic [2:0] n
  );
    return OPT_EN ? mk_slot(K_OPT, l, n) : f_idle();
  endfunction

  function automatic fetch_slot_type fetch_slot(
    input logic [2:0] mode,
    input logic [2:0] slot
  );
    fetch_slot_type t [8];
    for (int i = 0; i < 8; i++) t[i] = f_idle();
    case (mode)
      3'd0: begin
        for (int i = 0; i < 4; i++) begin
          t[i]   = f_map(2'(i));
          t[i+4] = f_dat(2'(i), 3'd0);
        end
      end
      3'd1: begin
        t[0] = f_map(2'd0);       t[1] = f_map(2'd1);
        t[2] = f_map(2'd2);       t[3] = f_dat(2'd0, 3'd0);
        t[4] = f_dat(2'd0, 3'd2); t[5] = f_dat(2'd1, 3'd0);
        t[6] = f_dat(2'd1, 3'd2); t[7] = f_dat(2'd2, 3'd0);
      end
      3'd2: begin
        t[0] = f_map(2'd0);       t[1] = f_map(2'd1);
        t[2] = f_opt(2'd2, 3'd0); t[3] = f_opt(2'd2, 3'd1);
        t[4] = f_dat(2'd0, 3'd0); t[5] = f_dat(2'd0, 3'd2);
        t[6] = f_dat(2'd1, 3'd0); t[7] = f_dat(2'd1, 3'd2);
      end
      3'd3: begin
        t[0] = f_map(2'd0);       t[1] = f_map(2'd1);
        t[2] = f_dat(2'd0, 3'd0); t[3] = f_dat(2'd0, 3'd2);
        t[4] = f_dat(2'd0, 3'd4); t[5] = f_dat(2'd0, 3'd6);
        t[6] = f_dat(2'd1, 3'd0); t[7] = f_dat(2'd1, 3'd2);
      end
      3'd4: begin
        t[0] = f_map(2'd0);       t[1] = f_map(2'd1);
        t[2] = f_opt(2'd2, 3'd0); t[3] = f_dat(2'd0, 3'd0);
        t[4] = f_dat(2'd0, 3'd2); t[5] = f_dat(2'd0, 3'd4);
        t[6] = f_dat(2'd0, 3'd6); t[7] = f_dat(2'd1, 3'd0);
      end
      3'd5: begin
        t[0] = f_map(2'd0);       t[1] = f_map(2'd1);
        t[2] = f_dat(2'd0, 3'd0); t[3] = f_dat(2'd0, 3'd1);
        t[4] = f_dat(2'd0, 3'd2); t[5] = f_dat(2'd0, 3'd3);
        t[6] = f_dat(2'd1, 3'd0); t[7] = f_dat(2'd1, 3'd1);
      end
      3'd6: begin
        t[0] = f_map(2'd0);       t[1] = f_opt(2'd2, 3'd0);
        t[2] = f_opt(2'd2, 3'd1); t[3] = f_dat(2'd0, 3'd0);
        t[4] = f_dat(2'd0, 3'd1); t[5] = f_dat(2'd0, 3'd2);
        t[6] = f_dat(2'd0, 3'd3);
      end
      default: ;
    endcase
    return t[slot];
  endfunction

  // lmode packs BG4..BG1 from msb to lsb
  function automatic layer_cfg_t layer_cfg(input logic [2:0] mode);
    layer_cfg_t c;
    c.lmode = '0;
    c.en    = '0;
    case (mode)
      3'd0: begin
        c.lmode = {LM_2BPP, LM_2BPP, LM_2BPP, LM_2BPP};
        c.en    = 4'b1111;
      end
      3'd1: begin
        c.lmode = {3'b000, LM_2BPP, LM_4BPP, LM_4BPP};
        c.en    = 4'b0111;
      end
      3'd2: begin
        c.lmode = {3'b000, LM_OPT2, LM_4BPP, LM_4BPP};
        c.en    = {1'b0, OPT_EN, 2'b11};
      end
      3'd3: begin
        c.lmode = {3'b000, 3'b000, LM_4BPP, LM_8BPP};
        c.en    = 4'b0011;
      end
      3'd4: begin
        c.lmode = {3'b000, OPT_EN ? LM_OPT4 : LM_OPT2,
                   LM_2BPP, LM_8BPP};
        c.en    = {1'b0, OPT_EN, 2'b11};
      end
      3'd5: begin
        c.lmode = {3'b000, 3'b000, LM_HI2, LM_HI4};
        c.en    = 4'b0011;
      end
      3'd6: begin
        c.lmode = {3'b000, LM_OPT2, 3'b000, LM_HI4};
        c.en    = {1'b0, OPT_EN, 1'b0, 1'b1};
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bg_fetch_decode.sv
// Combinational slot decoder: schedule entry to per-layer strobes.
// Honours BG_FETCH_OPT_EN through the shared schedule table.
module bg_fetch_decode
  import ppu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [2:0]  slot_i,
  input  logic        active_i,
  output logic [3:0]  fetch_map_o,
  output logic [3:0]  fetch_data_o,
  output logic [11:0] fetch_num_o,
  output logic [2:0]  vram_sel_o
);

  fetch_slot_type s;
  logic           hit;

  always_comb begin
    s            = fetch_slot(mode_i, slot_i);
    hit          = active_i && (s.kind != K_IDLE);
    fetch_map_o  = '0;
    fetch_data_o = '0;
    fetch_num_o  = '0;
    vram_sel_o   = VRAM_SEL_NONE;
    if (hit) begin
      vram_sel_o = {1'b0, s.layer};
      for (int i = 0; i < 4; i++) begin
        if (s.layer == 2'(i)) begin
          fetch_map_o[i]       = (s.kind != K_DATA);
          fetch_data_o[i]      = (s.kind == K_DATA);
          fetch_num_o[i*3 +: 3] = s.num;
        end
      end
    end
  end

endmodule

// File: rtl/bg_fetch_sched.sv
// Per-scanline BG VRAM fetch scheduler: line FSM, fetch-x counter, slot decode.
// BG_FETCH_OPT_EN enables the OPT map slots of modes 2, 4 and 6.
module bg_fetch_sched
  import ppu_pkg::*;
#(
  parameter int LINE_DOTS = 264
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dot_en,
  input  logic        line_start,
  input  logic [7:0]  y_in,
  input  logic [2:0]  bg_mode,
  input  logic        force_blank,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        newline,
  output logic [11:0] layer_mode,
  output logic [3:0]  layer_en,
  output logic [3:0]  fetch_map,
  output logic [3:0]  fetch_data,
  output logic [11:0] fetch_data_num,
  output logic [2:0]  vram_sel,
  output logic        vram_free
);

  localparam logic [8:0] X_LAST = 9'(LINE_DOTS - 1);

  fetch_state_t state_q, state_d;
  logic [8:0]   x_q, x_d;
  logic [7:0]   y_q, y_d;
  logic [2:0]   mode_q, mode_d;
  layer_cfg_t   cfg;
  logic         active;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
    end
  end

  // A line start restarts the window from any state
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    if (dot_en) begin
      if (line_start) begin
        state_d = ST_FETCH;
        x_d     = '0;
        y_d     = y_in;
        mode_d  = bg_mode;
      end else if (state_q == ST_FETCH) begin
        if (x_q == X_LAST) state_d = ST_HOLD;
        else               x_d     = x_q + 9'd1;
      end
    end
  end

  assign active  = (state_q == ST_FETCH) && !force_blank;
  assign cfg     = layer_cfg(mode_q);
  assign x       = x_q;
  assign y       = y_q;
  assign newline = reset_n && dot_en && line_start;

  assign layer_mode = (state_q != ST_IDLE) ? cfg.lmode : '0;
  assign layer_en   = (state_q != ST_IDLE) ? cfg.en    : '0;

  bg_fetch_decode u_dec (
    .mode_i       (mode_q),
    .slot_i       (x_q[2:0]),
    .active_i     (active),
    .fetch_map_o  (fetch_map),
    .fetch_data_o (fetch_data),
    .fetch_num_o  (fetch_data_num),
    .vram_sel_o   (vram_sel)
  );

  assign vram_free = (vram_sel == VRAM_SEL_NONE);

endmodule

// File: tb/tb_bg_fetch_sched.sv
// Directed bench for bg_fetch_sched.
// Expectations follow BG_FETCH_OPT_EN when it is defined.
module tb_bg_fetch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dot_en;
  logic        line_start;
  logic [7:0]  y_in;
  logic [2:0]  bg_mode;
  logic        force_blank;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        newline;
  logic [11:0] layer_mode;
  logic [3:0]  layer_en;
  logic [3:0]  fetch_map;
  logic [3:0]  fetch_data;
  logic [11:0] fetch_data_num;
  logic [2:0]  vram_sel;
  logic        vram_free;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bg_fetch_sched #(.LINE_DOTS(264)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dot_en         (dot_en),
    .line_start     (line_start),
    .y_in           (y_in),
    .bg_mode        (bg_mode),
    .force_blank    (force_blank),
    .x              (x),
    .y              (y),
    .newline        (newline),
    .layer_mode     (layer_mode),
    .layer_en       (layer_en),
    .fetch_map      (fetch_map),
    .fetch_data     (fetch_data),
    .fetch_data_num (fetch_data_num),
    .vram_sel       (vram_sel),
    .vram_free      (vram_free)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [2:0] m, input logic [7:0] yy);
    bg_mode    = m;
    y_in       = yy;
    line_start = 1'b1;
    #1;
    check("newline", 32'(newline), 32'd1);
    adv();
    line_start = 1'b0;
    #1;
  endtask

  logic [3:0]  m1_map [8] = '{4'd1, 4'd2, 4'd4, 4'd0,
                              4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0]  m1_dat [8] = '{4'd0, 4'd0, 4'd0, 4'd1,
                              4'd1, 4'd2, 4'd2, 4'd4};
  logic [2:0]  m1_sel [8] = '{3'd0, 3'd1, 3'd2, 3'd0,
                              3'd0, 3'd1, 3'd1, 3'd2};
  logic [11:0] m1_num [8] = '{12'h0, 12'h0, 12'h0, 12'h0,
                              12'h002, 12'h0, 12'h010, 12'h0};

  logic bad, bad_x;

  initial begin
    reset_n     = 1'b0;
    dot_en      = 1'b1;
    line_start  = 1'b0;
    y_in        = 8'd0;
    bg_mode     = 3'd0;
    force_blank = 1'b0;
    repeat (3) adv();

    check("rst_x",     32'(x),              32'd0);
    check("rst_y",     32'(y),              32'd0);
    check("rst_nl",    32'(newline),        32'd0);
    check("rst_lmode", 32'(layer_mode),     32'd0);
    check("rst_len",   32'(layer_en),       32'd0);
    check("rst_map",   32'(fetch_map),      32'd0);
    check("rst_dat",   32'(fetch_data),     32'd0);
    check("rst_num",   32'(fetch_data_num), 32'd0);
    check("rst_sel",   32'(vram_sel),       32'd4);
    check("rst_free",  32'(vram_free),      32'd1);
    reset_n = 1'b1;
    adv();

    // mode 1: two slot periods
    start_line(3'd1, 8'd5);
    check("m1_y",     32'(y),          32'd5);
    check("m1_lmode", 32'(layer_mode), 32'h052);
    check("m1_len",   32'(layer_en),   32'h7);
    for (int i = 0; i < 16; i++) begin
      check("m1_x",    32'(x),              32'(i));
      check("m1_map",  32'(fetch_map),      32'(m1_map[i%8]));
      check("m1_dat",  32'(fetch_data),     32'(m1_dat[i%8]));
      check("m1_sel",  32'(vram_sel),       32'(m1_sel[i%8]));
      check("m1_num",  32'(fetch_data_num), 32'(m1_num[i%8]));
      check("m1_free", 32'(vram_free),      32'd0);
      adv();
    end

    // dot_en low freezes x
    dot_en = 1'b0;
    adv();
    check("hold_x",   32'(x),         32'd16);
    check("hold_map", 32'(fetch_map), 32'd1);
    dot_en = 1'b1;
    #1;

    // mode 2, restarting mid-line
    start_line(3'd2, 8'd6);
    check("m2_x0",    32'(x),          32'd0);
    check("m2_lmode", 32'(layer_mode), 32'h012);
    adv();
    adv();
`ifdef BG_FETCH_OPT_EN
    check("m2_len",   32'(layer_en),       32'h7);
    check("m2_map2",  32'(fetch_map),      32'h4);
    check("m2_num2",  32'(fetch_data_num), 32'h0);
    check("m2_sel2",  32'(vram_sel),       32'd2);
    check("m2_free2", 32'(vram_free),      32'd0);
    adv();
    check("m2_map3",  32'(fetch_map),      32'h4);
    check("m2_num3",  32'(fetch_data_num), 32'h040);
    check("m2_sel3",  32'(vram_sel),       32'd2);
`else
    check("m2_len",   32'(layer_en),       32'h3);
    check("m2_map2",  32'(fetch_map),      32'h0);
    check("m2_sel2",  32'(vram_sel),       32'd4);
    check("m2_free2", 32'(vram_free),      32'd1);
    adv();
    check("m2_map3",  32'(fetch_map),      32'h0);
    check("m2_sel3",  32'(vram_sel),       32'd4);
    check("m2_free3", 32'(vram_free),      32'd1);
`endif
    adv();
    check("m2_dat4", 32'(fetch_data), 32'h1);

    // mode 7: one full idle line then HOLD
    start_line(3'd7, 8'd7);
    bad = 1'b0;
    for (int i = 0; i < 264; i++) begin
      bad |= (x != 9'(i)) || ((fetch_map | fetch_data) != 4'd0)
          || !vram_free || (vram_sel != 3'd4);
      adv();
    end
    check("m7_line", 32'(bad),      32'd0);
    check("m7_len",  32'(layer_en), 32'd0);
    check("m7_x",    32'(x),        32'd263);
    adv();
    adv();
    check("m7_hold", 32'(x),        32'd263);

    // bg_mode change mid-line is deferred
    start_line(3'd0, 8'd8);
    repeat (100) adv();
    check("sw_x100", 32'(x), 32'd100);
    bg_mode = 3'd3;
    #1;
    adv();
    check("sw_dat5",   32'(fetch_data), 32'h2);
    check("sw_sel5",   32'(vram_sel),   32'd1);
    check("sw_lmode0", 32'(layer_mode), 32'h249);
    adv();
    check("sw_dat6",   32'(fetch_data), 32'h4);
    start_line(3'd3, 8'd9);
    adv();
    adv();
    check("sw_dat_m3",  32'(fetch_data),     32'h1);
    check("sw_sel_m3",  32'(vram_sel),       32'd0);
    check("sw_num_m3",  32'(fetch_data_num), 32'd0);
    check("sw_lmode3",  32'(layer_mode),     32'h013);
    check("sw_len3",    32'(layer_en),       32'h3);

    // force_blank over x = 40..47
    start_line(3'd0, 8'd10);
    bad   = 1'b0;
    bad_x = 1'b0;
    for (int i = 0; i < 264; i++) begin
      force_blank = (i >= 40) && (i <= 47);
      #1;
      if (force_blank)
        bad |= ((fetch_map | fetch_data) != 4'd0)
            || (vram_sel != 3'd4) || !vram_free;
      else
        bad |= vram_free;
      bad_x |= (x != 9'(i));
      if (i == 44) check("fb_sel44", 32'(vram_sel), 32'd4);
      if (i == 48) check("fb_map48", 32'(fetch_map), 32'h1);
      adv();
    end
    force_blank = 1'b0;
    #1;
    check("fb_window", 32'(bad),   32'd0);
    check("fb_xrun",   32'(bad_x), 32'd0);
    check("fb_xend",   32'(x),     32'd263);
    repeat (3) adv();
    check("fb_hold_x",   32'(x),        32'd263);
    check("fb_hold_sel", 32'(vram_sel), 32'd4);

    // reset mid-line
    start_line(3'd1, 8'd11);
    repeat (130) adv();
    check("rs_x130", 32'(x), 32'd130);
    reset_n = 1'b0;
    #1;
    adv();
    check("rs_x",     32'(x),          32'd0);
    check("rs_y",     32'(y),          32'd0);
    check("rs_sel",   32'(vram_sel),   32'd4);
    check("rs_free",  32'(vram_free),  32'd1);
    check("rs_len",   32'(layer_en),   32'd0);
    check("rs_lmode", 32'(layer_mode), 32'd0);
    reset_n = 1'b1;
    #1;
    bad = 1'b0;
    repeat (10) begin
      adv();
      bad |= ((fetch_map | fetch_data) != 4'd0) || (x != 9'd0)
          || !vram_free;
    end
    check("rs_idle", 32'(bad), 32'd0);
    start_line(3'd0, 8'd12);
    check("rs_resume_sel", 32'(vram_sel),  32'd0);
    check("rs_resume_map", 32'(fetch_map), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
